// File: rtl/adder_axi_master.sv
// AXI4-Lite master that sequences one add operation on the memory-mapped adder slave:
// write A (0x0), write B (0x4), read sum (0x8), read overflow flag (0xC).
module adder_axi_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      m1_axi_aclk,
  input  logic                      m1_axi_areset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      overflow,
  output logic                      error,
  output logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
  output logic                      m1_axi_awvalid,
  input  logic                      m1_axi_awready,
  output logic [DATA_WIDTH-1:0]     m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
  output logic                      m1_axi_wvalid,
  input  logic                      m1_axi_wready,
  input  logic [RESP_WIDTH-1:0]     m1_axi_bresp,
  input  logic                      m1_axi_bvalid,
  output logic                      m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
  output logic                      m1_axi_arvalid,
  input  logic                      m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m1_axi_rdata,
  input  logic [RESP_WIDTH-1:0]     m1_axi_rresp,
  input  logic                      m1_axi_rvalid,
  output logic                      m1_axi_rready
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(32'h0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(32'h4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SUM = ADDR_WIDTH'(32'h8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = ADDR_WIDTH'(32'hC);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_RD_RES,
    S_RD_OVF,
    S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    timed_out;

  // Next-state, handshake tracking and entry actions for each bus phase
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    overflow_d = overflow_q;
    result_d   = result_q;
    op_b_d     = op_b_q;
    awaddr_d   = awaddr_q;
    awvalid_d  = awvalid_q;
    wdata_d    = wdata_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    timed_out  = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR_A;
          op_b_d  = op_b;
          busy_d  = 1'b1;
          error_d = 1'b0;
        end
      end
      S_WR_A, S_WR_B: begin
        if (awvalid_q && m1_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m1_axi_wready)   wvalid_d  = 1'b0;
        if (bready_q && m1_axi_bvalid) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          if (m1_axi_bresp != '0) begin
            error_d = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = (state_q == S_WR_A) ? S_WR_B : S_RD_RES;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_RD_RES, S_RD_OVF: begin
        // slave may answer without ever raising arready, so rvalid also retires the address
        if (arvalid_q && (m1_axi_arready || m1_axi_rvalid)) arvalid_d = 1'b0;
        if (rready_q && m1_axi_rvalid) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          if (state_q == S_RD_RES) result_d   = m1_axi_rdata;
          else                     overflow_d = m1_axi_rdata[0];
          if (m1_axi_rresp != '0) begin
            error_d = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = (state_q == S_RD_RES) ? S_RD_OVF : S_FIN;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Entry actions: a phase raises its valids/readies on its first cycle
    if (state_d != state_q) begin
      case (state_d)
        S_WR_A: begin
          awaddr_d  = ADDR_A;
          wdata_d   = op_a;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
        end
        S_WR_B: begin
          awaddr_d  = ADDR_B;
          wdata_d   = op_b_q;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
        end
        S_RD_RES: begin
          araddr_d  = ADDR_SUM;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
        end
        S_RD_OVF: begin
          araddr_d  = ADDR_OVF;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
        end
        S_FIN: begin
          done_d    = 1'b1;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Per-phase cycle counter, restarted on every state change
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
  end

  // State and output registers
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
      op_b_q     <= '0;
      awaddr_q   <= '0;
      awvalid_q  <= 1'b0;
      wdata_q    <= '0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
      op_b_q     <= op_b_d;
      awaddr_q   <= awaddr_d;
      awvalid_q  <= awvalid_d;
      wdata_q    <= wdata_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign overflow       = overflow_q;
  assign result         = result_q;
  assign m1_axi_awaddr  = awaddr_q;
  assign m1_axi_awvalid = awvalid_q;
  assign m1_axi_wdata   = wdata_q;
  assign m1_axi_wstrb   = {STRB_W{1'b1}};
  assign m1_axi_wvalid  = wvalid_q;
  assign m1_axi_bready  = bready_q;
  assign m1_axi_araddr  = araddr_q;
  assign m1_axi_arvalid = arvalid_q;
  assign m1_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_axi_master.sv
// Directed bench for adder_axi_master with a small registered adder-slave model.
module tb_adder_axi_master;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, overflow, error;
  logic [31:0] result;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int tests_run;
  int tests_failed;

  // slave behaviour knobs
  logic stall_b;
  logic bresp_err_a;
  logic no_arready;

  // slave state and monitors
  logic [31:0] reg_a, reg_b;
  logic [32:0] sum33;
  int          ar_wait;
  int          wr_b_cnt;
  int          ar_cyc_cnt;
  int          aw_cyc_cnt;
  int          done_cnt;

  adder_axi_master dut (
    .m1_axi_aclk    (clk),
    .m1_axi_areset  (rst),
    .start          (start),
    .op_a           (op_a),
    .op_b           (op_b),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .overflow       (overflow),
    .error          (error),
    .m1_axi_awaddr  (awaddr),
    .m1_axi_awvalid (awvalid),
    .m1_axi_awready (awready),
    .m1_axi_wdata   (wdata),
    .m1_axi_wstrb   (wstrb),
    .m1_axi_wvalid  (wvalid),
    .m1_axi_wready  (wready),
    .m1_axi_bresp   (bresp),
    .m1_axi_bvalid  (bvalid),
    .m1_axi_bready  (bready),
    .m1_axi_araddr  (araddr),
    .m1_axi_arvalid (arvalid),
    .m1_axi_arready (arready),
    .m1_axi_rdata   (rdata),
    .m1_axi_rresp   (rresp),
    .m1_axi_rvalid  (rvalid),
    .m1_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign awready = 1'b1;
  assign wready  = 1'b1;
  assign arready = ~no_arready;
  assign rresp   = 3'd0;
  assign sum33   = {1'b0, reg_a} + {1'b0, reg_b};

  // Adder slave: registered responses, one cycle after the request handshake
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      ar_wait  <= 0;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (awvalid && awready && wvalid && wready) begin
        if (awaddr == 8'h0) reg_a <= wdata;
        if (awaddr == 8'h4) reg_b <= wdata;
        bresp <= (bresp_err_a && awaddr == 8'h0) ? 3'd2 : 3'd0;
        if (!(stall_b && awaddr == 8'h4)) bvalid <= 1'b1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (arvalid && !rvalid) begin
        if (!no_arready || ar_wait == 2) begin
          rvalid  <= 1'b1;
          ar_wait <= 0;
          rdata   <= (araddr == 8'h8) ? sum33[31:0] :
                     (araddr == 8'hC) ? {31'd0, sum33[32]} : 32'hDEADBEEF;
        end else begin
          ar_wait <= ar_wait + 1;
        end
      end
    end
  end

  // Bus activity monitors (not reset, so they span DUT resets)
  always @(posedge clk) begin
    if (awvalid && awready && awaddr == 8'h4) wr_b_cnt <= wr_b_cnt + 1;
    if (arvalid) ar_cyc_cnt <= ar_cyc_cnt + 1;
    if (awvalid) aw_cyc_cnt <= aw_cyc_cnt + 1;
    if (done)    done_cnt   <= done_cnt + 1;
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the edge that accepted start
  task automatic wait_done(input int limit, output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    while (cyc <= limit) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, done, error, overflow} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_status: got %b expected 0000", {busy, done, error, overflow});
    end
    tests_run++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_handshake: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    tests_run++;
    if ({result, awaddr, araddr, wdata} !== 80'd0) begin
      tests_failed++;
      $display("FAIL reset_data: result=%0h awaddr=%0h araddr=%0h wdata=%0h expected all 0", result, awaddr, araddr, wdata);
    end
  endtask

  task automatic test_basic_add();
    int cyc; bit ok;
    do_start(32'd5, 32'd7);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    wait_done(40, cyc, ok);
    tests_run++;
    if (!ok || cyc != 9) begin
      tests_failed++;
      $display("FAIL basic_latency: got ok=%0d cyc=%0d expected cyc=9", ok, cyc);
    end
    tests_run++;
    if (reg_a !== 32'd5 || reg_b !== 32'd7 || wstrb !== 4'hF) begin
      tests_failed++;
      $display("FAIL basic_writes: got a=%0h b=%0h strb=%0h expected 5 7 f", reg_a, reg_b, wstrb);
    end
    tests_run++;
    if (result !== 32'd12 || overflow !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: got res=%0h ovf=%b err=%b expected c 0 0", result, overflow, error);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back_overflow();
    int cyc; bit ok;
    do_start(32'hFFFF_FFFF, 32'd1);
    wait_done(40, cyc, ok);
    tests_run++;
    if (!ok || cyc != 9) begin
      tests_failed++;
      $display("FAIL ovf_latency: got ok=%0d cyc=%0d expected cyc=9", ok, cyc);
    end
    tests_run++;
    if (result !== 32'h0 || overflow !== 1'b1 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_result: got res=%0h ovf=%b err=%b expected 0 1 0", result, overflow, error);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit ok; int ar0;
    stall_b = 1'b1;
    ar0 = ar_cyc_cnt;
    do_start(32'd3, 32'd4);
    wait_done(400, cyc, ok);
    tests_run++;
    if (!ok || cyc != 258) begin
      tests_failed++;
      $display("FAIL timeout_latency: got ok=%0d cyc=%0d expected cyc=258", ok, cyc);
    end
    tests_run++;
    if (error !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_error: got %b expected 1", error);
    end
    tests_run++;
    if (ar_cyc_cnt != ar0 || {awvalid, wvalid, bready, arvalid, rready} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL timeout_bus_quiet: got reads=%0d hs=%b expected 0 00000", ar_cyc_cnt - ar0, {awvalid, wvalid, bready, arvalid, rready});
    end
    stall_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bresp_error();
    int cyc; bit ok; int ar0; int wb0;
    bresp_err_a = 1'b1;
    ar0 = ar_cyc_cnt;
    wb0 = wr_b_cnt;
    do_start(32'd8, 32'd9);
    wait_done(40, cyc, ok);
    tests_run++;
    if (!ok || cyc != 3) begin
      tests_failed++;
      $display("FAIL bresp_latency: got ok=%0d cyc=%0d expected cyc=3", ok, cyc);
    end
    tests_run++;
    if (error !== 1'b1 || wr_b_cnt != wb0 || ar_cyc_cnt != ar0) begin
      tests_failed++;
      $display("FAIL bresp_abort: got err=%b wrB=%0d reads=%0d expected 1 0 0", error, wr_b_cnt - wb0, ar_cyc_cnt - ar0);
    end
    bresp_err_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_arready();
    int cyc; bit ok;
    no_arready = 1'b1;
    do_start(32'd100, 32'd23);
    wait_done(100, cyc, ok);
    tests_run++;
    if (!ok || cyc != 13) begin
      tests_failed++;
      $display("FAIL noar_latency: got ok=%0d cyc=%0d expected cyc=13", ok, cyc);
    end
    tests_run++;
    if (result !== 32'd123 || overflow !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL noar_result: got res=%0h ovf=%b err=%b expected 7b 0 0", result, overflow, error);
    end
    no_arready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_and_busy_start();
    int d0; int aw0;
    do_start(32'd10, 32'd20);       // now in cycle 1
    @(negedge clk);                 // cycle 2
    start = 1'b1;
    op_a  = 32'd99;
    op_b  = 32'd99;
    @(negedge clk);                 // cycle 3
    start = 1'b0;
    @(negedge clk);                 // cycle 4
    @(negedge clk);                 // cycle 5: first RD_RES cycle
    tests_run++;
    if (arvalid !== 1'b1 || busy !== 1'b1 || reg_b !== 32'd20) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: got arvalid=%b busy=%b regB=%0d expected 1 1 20", arvalid, busy, reg_b);
    end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({arvalid, rready, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset: got arvalid/rready/busy=%b expected 000", {arvalid, rready, busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    aw0 = aw_cyc_cnt;
    repeat (12) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 || aw_cyc_cnt != aw0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got dones=%0d aw_cycles=%0d busy=%b expected 0 0 0", done_cnt - d0, aw_cyc_cnt - aw0, busy);
    end
    tests_run++;
    if (result !== 32'd0 || error !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got res=%0h err=%b ovf=%b expected 0 0 0", result, error, overflow);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wr_b_cnt     = 0;
    ar_cyc_cnt   = 0;
    aw_cyc_cnt   = 0;
    done_cnt     = 0;
    rst          = 1'b1;
    start        = 1'b0;
    op_a         = '0;
    op_b         = '0;
    stall_b      = 1'b0;
    bresp_err_a  = 1'b0;
    no_arready   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic_add();
    test_back_to_back_overflow();
    test_timeout();
    test_bresp_error();
    test_no_arready();
    test_reset_mid_and_busy_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
